pattern_decoder: RTL

- Receiving end of the pattern_gen serial interface.
- Samples the 1-bit `pattern` stream while `valid` is high and reassembles 4-bit frames, MSB first.
- Each frame is checked for the redundant MSB (f3 must equal f2) and decoded back to the 3-bit `sel` code.
- Keeps saturating counts of good and bad frames; sits directly downstream of pattern_gen in loopback and self-test setups.

---
 rtl/pattern_decoder.sv | 82 ++++++++
 1 files changed

// File: rtl/pattern_decoder.sv
// pattern_decoder: receives serial 4-bit frames, MSB first, from pattern_gen.
// It checks the redundant MSB, decodes the 3-bit sel code and keeps saturating frame/error counts.
`default_nettype none

module pattern_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             pattern,
  input  logic             clr,
  output logic [2:0]       sel_out,
  output logic             out_valid,
  output logic             err,
  output logic             abort,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX1  = 2'd1,
    RX2  = 2'd2,
    RX3  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     bcnt;
  logic [2:0] shreg;
  logic       complete;
  logic       frame_err;

  // shreg[2:1] hold f3/f2 once three bits are in, so the MSB check is ready at f0.
  assign complete  = valid && (bcnt == RX3);
  assign frame_err = shreg[2] ^ shreg[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt      <= IDLE;
      shreg     <= 3'b000;
      sel_out   <= 3'b000;
      out_valid <= 1'b0;
      err       <= 1'b0;
      abort     <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      out_valid <= 1'b0;
      err       <= 1'b0;
      abort     <= 1'b0;

      if (valid) begin
        shreg <= {shreg[1:0], pattern};
        bcnt  <= state_t'(bcnt + 2'd1);
        if (bcnt == RX3) begin
          sel_out   <= {shreg[1:0], pattern};
          err       <= frame_err;
          out_valid <= 1'b1;
        end
      end else if (bcnt != IDLE) begin
        bcnt  <= IDLE;
        shreg <= 3'b000;
        abort <= 1'b1;
      end

      // A clear wins over a same-cycle increment; the frame in flight is unaffected.
      if (clr) begin
        frame_cnt <= '0;
        err_cnt   <= '0;
      end else if (complete) begin
        if (frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + CNT_ONE;
        if (frame_err && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire
